// File: rtl/mc_step_sequencer.sv
// mc_step_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Timestamps each instruction against the upstream 5-bit cycle counter and
// reports the elapsed cycle count on completion. Memory waits are bounded by
// MEM_TIMEOUT. Optional retire/error statistics under `MC_SEQ_STATS_EN.
module mc_step_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned OP_W        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    input  logic [4:0]      cyc_in,
    output logic [2:0]      state,
    output logic            busy,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            ir_we,
    output logic            pc_we,
    output logic            alu_en,
    output logic            reg_we,
    output logic            done,
    output logic            err,
    output logic [4:0]      instr_cycles
`ifdef MC_SEQ_STATS_EN
    ,
    output logic [15:0]     retired_cnt,
    output logic [7:0]      err_cnt
`endif
);

    localparam int unsigned CYC_W = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Instruction class latched in DECODE; only ALU/LOAD/STORE reach EXEC.
    localparam logic [1:0] K_ALU   = 2'd1;
    localparam logic [1:0] K_LOAD  = 2'd2;
    localparam logic [1:0] K_STORE = 2'd3;

    state_t           state_q;
    state_t           state_nxt;
    logic             abort_c;
    logic             wait_tmo_c;
    logic [CYC_W-1:0] stamp;
    logic [CYC_W-1:0] wait_cnt;
    logic [1:0]       op_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; abort_c flags a timeout or illegal opcode on entry to DONE.
    always_comb begin
        state_nxt  = state_q;
        abort_c    = 1'b0;
        wait_tmo_c = (wait_cnt == CYC_W'(MEM_TIMEOUT - 1));
        case (state_q)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt = S_DECODE;
                end else if (wait_tmo_c) begin
                    state_nxt = S_DONE;
                    abort_c   = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_W'(0)) begin
                    state_nxt = S_DONE;
                end else if (opcode <= OP_W'(3)) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_DONE;
                    abort_c   = 1'b1;
                end
            end
            S_EXEC: begin
                state_nxt = (op_q == K_ALU) ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_nxt = (op_q == K_LOAD) ? S_WB : S_DONE;
                end else if (wait_tmo_c) begin
                    state_nxt = S_DONE;
                    abort_c   = 1'b1;
                end
            end
            S_WB:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore strobe decode; ir_we/pc_we additionally qualify on mem_ready.
    always_comb begin
        busy   = 1'b1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        ir_we  = 1'b0;
        pc_we  = 1'b0;
        alu_en = 1'b0;
        reg_we = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            S_EXEC:  alu_en = 1'b1;
            S_MEM: begin
                mem_rd = (op_q == K_LOAD);
                mem_wr = (op_q == K_STORE);
            end
            S_WB:    reg_we = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

    // Timestamp, wait counter, opcode class and registered completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp        <= '0;
            wait_cnt     <= '0;
            op_q         <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            instr_cycles <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                stamp    <= cyc_in;
                wait_cnt <= '0;
            end
            if (state_q == S_EXEC) begin
                wait_cnt <= '0;
            end
            if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + CYC_W'(1);
            end
            if (state_q == S_DECODE) begin
                op_q <= 2'(opcode);
            end
            done <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE) begin
                err          <= abort_c;
                instr_cycles <= cyc_in - stamp;
            end
        end
    end

`ifdef MC_SEQ_STATS_EN
    // Retire counter wraps; error counter saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            err_cnt     <= '0;
        end else if (state_nxt == S_DONE) begin
            if (abort_c) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
                retired_cnt <= retired_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_step_sequencer.sv
// Randomized self-checking bench for mc_step_sequencer. Each instruction is
// planned as an expected per-cycle state trace (with the mem_ready value the
// bench drives in each cycle); outputs are checked against that trace.
// Build with +define+MC_SEQ_STATS_EN to also check the statistics counters.
module tb_mc_step_sequencer;

    localparam int unsigned T    = 15;
    localparam int unsigned OP_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [OP_W-1:0] opcode;
    logic            mem_ready;
    logic [4:0]      cyc_in;
    logic [2:0]      state;
    logic            busy, mem_rd, mem_wr, ir_we, pc_we, alu_en, reg_we;
    logic            done, err;
    logic [4:0]      instr_cycles;
`ifdef MC_SEQ_STATS_EN
    logic [15:0]     retired_cnt;
    logic [7:0]      err_cnt;
`endif

    mc_step_sequencer #(.MEM_TIMEOUT(T), .OP_W(OP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .cyc_in       (cyc_in),
        .state        (state),
        .busy         (busy),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .alu_en       (alu_en),
        .reg_we       (reg_we),
        .done         (done),
        .err          (err),
        .instr_cycles (instr_cycles)
`ifdef MC_SEQ_STATS_EN
        ,
        .retired_cnt  (retired_cnt),
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ret_m   = 0;
    int err_m   = 0;
    int st_q[$];
    bit rd_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; the bench acts as the free-running cycle counter.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_in = cyc_in + 5'd1;
    endtask

    function automatic void push(input int s, input bit r);
        st_q.push_back(s);
        rd_q.push_back(r);
    endfunction

    // op: opcode; nf/nm: mem_ready-low cycles in FETCH/MEM; rst_at: trace index to reset at (-1 none).
    task automatic run_instr(input int op, input int nf, input int nm, input int rst_at);
        bit abort;
        int exp_cyc;
        int s;
        st_q.delete();
        rd_q.delete();
        abort = 1'b0;
        if (nf >= int'(T)) begin
            for (int i = 0; i < int'(T); i++) push(1, 1'b0);
            abort = 1'b1;
        end else begin
            for (int i = 0; i < nf; i++) push(1, 1'b0);
            push(1, 1'b1);
            push(2, 1'($urandom));
            if (op > 3) begin
                abort = 1'b1;
            end else if (op != 0) begin
                push(3, 1'($urandom));
                if (op == 1) begin
                    push(5, 1'($urandom));
                end else if (nm >= int'(T)) begin
                    for (int i = 0; i < int'(T); i++) push(4, 1'b0);
                    abort = 1'b1;
                end else begin
                    for (int i = 0; i < nm; i++) push(4, 1'b0);
                    push(4, 1'b1);
                    if (op == 2) push(5, 1'($urandom));
                end
            end
        end
        exp_cyc = st_q.size();
        push(6, 1'($urandom));

        start  = 1'b1;
        opcode = 4'($urandom);
        tick();
        for (int j = 0; j < st_q.size(); j++) begin
            s         = st_q[j];
            mem_ready = rd_q[j];
            start     = 1'($urandom);
            opcode    = (s == 2) ? 4'(op) : 4'($urandom);
            #1;
            chk("state",  32'(state),  32'(s));
            chk("busy",   32'(busy),   32'd1);
            chk("mem_rd", 32'(mem_rd), 32'(s == 1 || (s == 4 && op == 2)));
            chk("mem_wr", 32'(mem_wr), 32'(s == 4 && op == 3));
            chk("ir_we",  32'(ir_we),  32'(s == 1 && rd_q[j]));
            chk("pc_we",  32'(pc_we),  32'(s == 1 && rd_q[j]));
            chk("alu_en", 32'(alu_en), 32'(s == 3));
            chk("reg_we", 32'(reg_we), 32'(s == 5));
            chk("done",   32'(done),   32'(s == 6));
            if (s == 6) begin
                chk("err",          32'(err),          32'(abort));
                chk("instr_cycles", 32'(instr_cycles), 32'(exp_cyc % 32));
                if (abort) begin
                    if (err_m < 255) err_m++;
                end else begin
                    ret_m = (ret_m + 1) % 65536;
                end
            end
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_state",  32'(state),        32'd0);
                chk("rst_busy",   32'(busy),         32'd0);
                chk("rst_mem_wr", 32'(mem_wr),       32'd0);
                chk("rst_mem_rd", 32'(mem_rd),       32'd0);
                chk("rst_done",   32'(done),         32'd0);
                chk("rst_cycles", 32'(instr_cycles), 32'd0);
                ret_m = 0;
                err_m = 0;
                #1;
                rst   = 1'b0;
                start = 1'b0;
                return;
            end
            tick();
        end
        start = 1'b0;
        #1;
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_busy",  32'(busy),  32'd0);
        chk("idle_done",  32'(done),  32'd0);
`ifdef MC_SEQ_STATS_EN
        chk("retired_cnt", 32'(retired_cnt), 32'(ret_m));
        chk("err_cnt",     32'(err_cnt),     32'(err_m));
`endif
        repeat ($urandom_range(0, 2)) tick();
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(12, 18));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        int r;
        rst       = 1'b1;
        start     = 1'b0;
        opcode    = '0;
        mem_ready = 1'b1;
        cyc_in    = 5'd0;
        #1;
        chk("reset_state",  32'(state),        32'd0);
        chk("reset_busy",   32'(busy),         32'd0);
        chk("reset_done",   32'(done),         32'd0);
        chk("reset_err",    32'(err),          32'd0);
        chk("reset_cycles", 32'(instr_cycles), 32'd0);
        chk("reset_ir_we",  32'(ir_we),        32'd0);
        chk("reset_mem_rd", 32'(mem_rd),       32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        tick();

        cyc_in = 5'd7;
        run_instr(1, 0, 0, -1);             // ALU, instr_cycles 4
        cyc_in = 5'd30;
        run_instr(2, 0, 3, -1);             // LOAD across counter wrap, 8
        run_instr(1, 20, 0, -1);            // FETCH timeout
        run_instr(9, 0, 0, -1);             // illegal opcode
        run_instr(0, 0, 0, -1);             // NOP, 2
        run_instr(3, 0, int'(T) - 1, -1);   // ready on timeout cycle succeeds
        run_instr(2, 0, int'(T) + 2, -1);   // MEM timeout
        run_instr(3, int'(T) - 1, 0, -1);   // ready on FETCH timeout cycle
        run_instr(3, 0, 6, 4);              // reset mid-MEM with mem_wr high
        for (int k = 0; k < 3; k++) run_instr(3, pick_wait() % 4, pick_wait() % 4, -1);
        run_instr(12, 0, 0, -1);
`ifdef MC_SEQ_STATS_EN
        chk("stats_retired", 32'(retired_cnt), 32'd3);
        chk("stats_err",     32'(err_cnt),     32'd1);
`endif

        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            run_instr((r < 8) ? (r % 4) : int'($urandom_range(4, 15)), pick_wait(), pick_wait(), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_step_sequencer.md
Name: mc_step_sequencer

Overview:
- Multi-cycle control FSM, directly downstream of the free-running 5-bit cycle counter; consumes its count value on `cyc_in`.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath write/enable strobes.
- Timestamps each instruction against `cyc_in` and reports its cycle count on completion.
- Guards memory waits with a timeout.

Parameters:
- MEM_TIMEOUT, 15: max cycles spent in FETCH or MEM with mem_ready low before abort; legal range 1..31.
- OP_W, 4: opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin one instruction; sampled only in IDLE.
- opcode  input  OP_W  instruction opcode from IR; sampled in DECODE.
- mem_ready  input  1  memory completes the access this cycle.
- cyc_in  input  5  cycle count from the upstream counter; wraps 31->0.
- state  output  3  current state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, DONE=6.
- busy  output  1  high in every state except IDLE.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- ir_we  output  1  instruction register write.
- pc_we  output  1  PC increment.
- alu_en  output  1  ALU operate.
- reg_we  output  1  register file write.
- done  output  1  one-cycle completion pulse.
- err  output  1  instruction aborted; valid while done=1.
- instr_cycles  output  5  cycles taken by the instruction; valid while done=1, held until next DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All strobes, busy, done, err = 0.
  - instr_cycles=0; internal stamp and wait_cnt = 0.
  - Takes effect immediately, mid-instruction included; no strobe survives reset.
- Strobes (mem_rd, mem_wr, ir_we, pc_we, alu_en, reg_we, busy) are Moore decodes of the state register, with no combinational path from inputs. Exception: ir_we and pc_we also qualify on mem_ready.
- done, err and instr_cycles are registered.
- IDLE:
  - start=1 -> FETCH at next edge; stamp<=cyc_in; wait_cnt<=0.
  - start while busy is ignored.
- FETCH:
  - mem_rd=1.
  - mem_ready=1: ir_we=1, pc_we=1 in that cycle; -> DECODE.
  - Otherwise wait_cnt++.
  - If wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: -> DONE with err.
- DECODE (1 cycle), branch on opcode:
  - 0 NOP -> DONE.
  - 1 ALU, 2 LOAD, 3 STORE -> EXEC.
  - 4..15 illegal -> DONE with err.
- EXEC (1 cycle): alu_en=1.
  - ALU -> WB.
  - LOAD/STORE -> MEM; wait_cnt<=0.
- MEM:
  - mem_rd=1 for LOAD; mem_wr=1 for STORE.
  - Strobe held until mem_ready=1.
  - Completion: LOAD -> WB; STORE -> DONE.
  - Timeout rule identical to FETCH.
- WB (1 cycle): reg_we=1 -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
  - On the edge entering DONE: instr_cycles <= (cyc_in - stamp) mod 32, i.e. 5-bit subtraction that handles counter wrap.
  - err is set on that same edge if the cause was a timeout or an illegal opcode; otherwise it is cleared.
- Latency with mem_ready tied high (start sampled at edge E0):
  - NOP: DONE after 3 edges; instr_cycles=2.
  - ALU and STORE: instr_cycles=4.
  - LOAD: instr_cycles=5.
  - Each wait cycle adds 1.
- Simultaneous events:
  - mem_ready=1 on the timeout cycle counts as success, not error.
  - start arriving in DONE is ignored; it must be re-presented in IDLE.
- Instructions longer than 31 cycles alias modulo 32. This is acceptable because MEM_TIMEOUT ≤ 31 bounds each wait state.

Optional Feature:
- Macro MC_SEQ_STATS_EN.
- Defined:
  - Adds output retired_cnt[15:0] and output err_cnt[7:0], both reset to 0.
  - retired_cnt increments on each DONE with err=0 and wraps at 65535->0.
  - err_cnt increments on each DONE with err=1 and saturates at 255.
- Undefined: both ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start=1 with cyc_in=7, opcode=1, mem_ready=1 -> states 1,2,3,5,6,0; alu_en and reg_we each high exactly 1 cycle; done=1 with instr_cycles=4, err=0.
- LOAD (opcode=2), mem_ready low for 3 cycles in MEM, stamp=30 -> mem_rd held 4 cycles in MEM; instr_cycles=8 across the 31->0 wrap; reg_we pulses once.
- FETCH with mem_ready held low, MEM_TIMEOUT=15 -> exactly 15 cycles in FETCH, then done=1, err=1, no ir_we/pc_we pulse.
- opcode=9 -> DECODE goes straight to DONE; err=1; instr_cycles=2; alu_en never asserted.
- rst asserted while in MEM with mem_wr=1 -> mem_wr and busy drop immediately; state=0; instr_cycles=0. start after rst is released runs normally.
- MC_SEQ_STATS_EN: 3 good STOREs followed by 1 illegal opcode -> retired_cnt=3, err_cnt=1. start pulsed during busy -> counts unchanged.
